// File: rtl/dram_ddr_rdq_south.sv
// South-channel DDR read-data capture queue: absorbs non-stallable pad beats and hands them to the controller via valid/ready.
// Optional dropped-beat counter port enabled by defining DRAM_RDQ_OVF_CNT_EN.
module dram_ddr_rdq_south #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic           clk,
   input  logic           arst_l,
   input  logic           io_dram_data_valid_buf,
   input  logic [255:0]   io_dram_data_in_buf,
   input  logic [31:0]    io_dram_ecc_in_buf,
   input  logic           dram_io_channel_disabled_buf,
   input  logic           dram_rdq_ready,
   input  logic           dram_rdq_clr_ovf,
   output logic           dram_rdq_vld,
   output logic [255:0]   dram_rdq_data,
   output logic [31:0]    dram_rdq_ecc,
   output logic [AW:0]    dram_rdq_cnt,
   output logic           dram_rdq_ovf
`ifdef DRAM_RDQ_OVF_CNT_EN
   ,
   output logic [7:0]     dram_rdq_ovf_cnt
`endif
);

   logic [287:0] mem_q [DEPTH];
   logic [AW:0]  wptr_q, wptr_d;
   logic [AW:0]  rptr_q, rptr_d;
   logic [AW:0]  cnt_q, cnt_d;
   logic         ovf_q, ovf_d;

   logic empty, full, push, pop, drop, wr_en;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   // Disable gates the head immediately so no pop can slip through during the flush cycle.
   assign dram_rdq_vld = !empty && !dram_io_channel_disabled_buf;
   assign push  = io_dram_data_valid_buf && !dram_io_channel_disabled_buf;
   assign pop   = dram_rdq_vld && dram_rdq_ready;
   assign drop  = push && full && !pop;
   assign wr_en = push && !drop;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (dram_io_channel_disabled_buf) begin
         rptr_d = wptr_q;
      end else begin
         if (wr_en) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
         if (pop)   rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
      end
      cnt_d = wptr_d - rptr_d;
      ovf_d = drop | (ovf_q & ~dram_rdq_clr_ovf);
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   // When full with a simultaneous pop, wptr aliases the head slot, so the new beat reuses it.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= {io_dram_ecc_in_buf, io_dram_data_in_buf};
   end

   assign dram_rdq_data = mem_q[rptr_q[AW-1:0]][255:0];
   assign dram_rdq_ecc  = mem_q[rptr_q[AW-1:0]][287:256];
   assign dram_rdq_cnt  = cnt_q;
   assign dram_rdq_ovf  = ovf_q;

`ifdef DRAM_RDQ_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (dram_rdq_clr_ovf)
         ovf_cnt_d = drop ? 8'd1 : 8'd0;
      else if (drop && ovf_cnt_q != 8'hFF)
         ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) ovf_cnt_q <= '0;
      else         ovf_cnt_q <= ovf_cnt_d;
   end

   assign dram_rdq_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_dram_ddr_rdq_south.sv
// Bench for dram_ddr_rdq_south: directed scenarios then random traffic, checked against a queue-based reference model.
module tb_dram_ddr_rdq_south;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic           clk = 1'b0;
   logic           arst_l = 1'b0;
   logic           in_vld = 1'b0;
   logic [255:0]   in_data = '0;
   logic [31:0]    in_ecc = '0;
   logic           dis = 1'b0;
   logic           rdy = 1'b0;
   logic           clr = 1'b0;
   logic           out_vld;
   logic [255:0]   out_data;
   logic [31:0]    out_ecc;
   logic [AW:0]    out_cnt;
   logic           out_ovf;
`ifdef DRAM_RDQ_OVF_CNT_EN
   logic [7:0]     out_ovf_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [287:0] mq[$];
   bit           m_ovf = 1'b0;
   int           m_ovf_cnt = 0;

   always #5 clk = ~clk;

   dram_ddr_rdq_south #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk                          (clk),
      .arst_l                       (arst_l),
      .io_dram_data_valid_buf       (in_vld),
      .io_dram_data_in_buf          (in_data),
      .io_dram_ecc_in_buf           (in_ecc),
      .dram_io_channel_disabled_buf (dis),
      .dram_rdq_ready               (rdy),
      .dram_rdq_clr_ovf             (clr),
      .dram_rdq_vld                 (out_vld),
      .dram_rdq_data                (out_data),
      .dram_rdq_ecc                 (out_ecc),
      .dram_rdq_cnt                 (out_cnt),
      .dram_rdq_ovf                 (out_ovf)
`ifdef DRAM_RDQ_OVF_CNT_EN
      ,
      .dram_rdq_ovf_cnt             (out_ovf_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [255:0] rnd256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_outputs(input bit exp_vld);
      chk("vld", 288'(out_vld), 288'(exp_vld));
      chk("cnt", 288'(out_cnt), 288'(mq.size()));
      chk("ovf", 288'(out_ovf), 288'(m_ovf));
`ifdef DRAM_RDQ_OVF_CNT_EN
      chk("ovf_cnt", 288'(out_ovf_cnt), 288'(m_ovf_cnt));
`endif
      if (exp_vld) chk("head", {out_ecc, out_data}, mq[0]);
   endtask

   // One clock: apply inputs, compare against the model's current state, then advance the model.
   task automatic cycle(input bit v, input logic [255:0] d, input logic [31:0] e,
                        input bit dd, input bit r, input bit c);
      bit exp_vld, pop, full, drop;
      @(negedge clk);
      in_vld = v; in_data = d; in_ecc = e; dis = dd; rdy = r; clr = c;
      #1;
      exp_vld = (mq.size() != 0) && !dd;
      check_outputs(exp_vld);
      pop  = exp_vld && r;
      full = (mq.size() == DEPTH);
      drop = v && !dd && full && !pop;
      if (dd) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (v && !drop) mq.push_back({e, d});
      end
      if (c) begin
         m_ovf     = drop;
         m_ovf_cnt = drop ? 1 : 0;
      end else if (drop) begin
         m_ovf = 1'b1;
         if (m_ovf_cnt < 255) m_ovf_cnt++;
      end
   endtask

   task automatic idle(input bit r);
      cycle(1'b0, '0, '0, 1'b0, r, 1'b0);
   endtask

   task automatic push_beat(input int val, input bit r);
      cycle(1'b1, 256'(val), 32'(val) ^ 32'hA5, 1'b0, r, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_l = 1'b0;
      in_vld = 1'b0; dis = 1'b0; rdy = 1'b0; clr = 1'b0;
      #1;
      mq.delete();
      m_ovf = 1'b0;
      m_ovf_cnt = 0;
      check_outputs(1'b0);
      @(negedge clk);
      arst_l = 1'b1;
   endtask

   initial begin
      #1;
      check_outputs(1'b0);
      @(negedge clk);
      arst_l = 1'b1;

      // single beat
      cycle(1'b1, 256'h1, 32'hA5, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);

      // fill, overflow, clear, drain
      for (int i = 1; i <= 4; i++) push_beat(i, 1'b0);
      idle(1'b0);
      push_beat(5, 1'b0);
      idle(1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // full with simultaneous push and pop
      for (int i = 1; i <= 4; i++) push_beat(i, 1'b0);
      push_beat(9, 1'b1);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // streaming wrap-around
      for (int i = 0; i < 20; i++) push_beat(100 + i, 1'b1);
      idle(1'b1);

      // disable mid-stream
      for (int i = 1; i <= 3; i++) push_beat(20 + i, 1'b0);
      cycle(1'b1, 256'h77, 32'h77, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);

      // reset mid-stream
      for (int i = 1; i <= 3; i++) push_beat(30 + i, 1'b0);
      do_reset();
      push_beat(40, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 9) < 7, rnd256(), $urandom(),
               $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1,
               $urandom_range(0, 99) < 5);
      end
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
